// File: rtl/bk_arith_pkg.sv
// Shared arithmetic package for the Brent-Kung adder and subtractor datapaths.
// Holds the default operand width, the (generate, propagate) pair type, the
// prefix-tree mode selector and the single prefix combine operator used by
// every Brent-Kung tree in the arithmetic unit.
package bk_arith_pkg;

    localparam int unsigned BK_WIDTH = 32'd32;

    // One prefix node: group generate and group propagate.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Which half of the Brent-Kung network a tree instance implements.
    typedef enum logic [0:0] {
        UPSWEEP   = 1'b0,
        DOWNSWEEP = 1'b1
    } tree_mode_e;

    // Prefix operator: hi covers the more significant span, lo the span just below it.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t res;
        res.g = hi.g | (hi.p & lo.g);
        res.p = hi.p & lo.p;
        return res;
    endfunction

endpackage

// File: rtl/bk_prefix_tree.sv
// Combinational half of a Brent-Kung parallel-prefix network.
//   MODE = UPSWEEP   : LEVELS levels; level k merges node i, (i+1) mod 2^k == 0,
//                      with node i - 2^(k-1). Nodes 2^k-1 end up with full prefixes.
//   MODE = DOWNSWEEP : LEVELS-1 levels, k = LEVELS-1 .. 1; node i + 2^(k-1) is
//                      merged with the already complete node i = m*2^k - 1.
// Ports:
//   gp_in  : WIDTH prefix nodes entering this half of the network
//   gp_out : WIDTH prefix nodes leaving this half of the network
module bk_prefix_tree
    import bk_arith_pkg::*;
#(
    parameter int unsigned WIDTH = BK_WIDTH,
    parameter tree_mode_e  MODE  = UPSWEEP
) (
    input  gp_t [WIDTH-1:0] gp_in,
    output gp_t [WIDTH-1:0] gp_out
);

    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned IDX_W  = LEVELS;

    gp_t [WIDTH-1:0] node_s;

    // Within one level the target and source index sets are disjoint, so the
    // nodes can be updated in place level after level.
    if (MODE == UPSWEEP) begin : g_up
        int hi_idx_s;
        int lo_idx_s;

        // Up-sweep: build the power-of-two aligned group prefixes.
        always_comb begin
            node_s   = gp_in;
            hi_idx_s = 32'sd0;
            lo_idx_s = 32'sd0;
            for (int k = 32'sd1; k <= int'(LEVELS); k++) begin
                for (int i = (32'sd1 <<< k) - 32'sd1; i < int'(WIDTH); i += (32'sd1 <<< k)) begin
                    hi_idx_s = i;
                    lo_idx_s = i - (32'sd1 <<< (k - 32'sd1));
                    node_s[hi_idx_s[IDX_W-1:0]] = gp_combine(node_s[hi_idx_s[IDX_W-1:0]],
                                                             node_s[lo_idx_s[IDX_W-1:0]]);
                end
            end
        end
    end else begin : g_down
        int hi_idx_s;
        int lo_idx_s;

        // Down-sweep: fill in every prefix the up-sweep left incomplete.
        always_comb begin
            node_s   = gp_in;
            hi_idx_s = 32'sd0;
            lo_idx_s = 32'sd0;
            for (int k = int'(LEVELS) - 32'sd1; k >= 32'sd1; k--) begin
                for (int i = (32'sd1 <<< k) - 32'sd1;
                     i + (32'sd1 <<< (k - 32'sd1)) < int'(WIDTH);
                     i += (32'sd1 <<< k)) begin
                    hi_idx_s = i + (32'sd1 <<< (k - 32'sd1));
                    lo_idx_s = i;
                    node_s[hi_idx_s[IDX_W-1:0]] = gp_combine(node_s[hi_idx_s[IDX_W-1:0]],
                                                             node_s[lo_idx_s[IDX_W-1:0]]);
                end
            end
        end
    end

    assign gp_out = node_s;

endmodule

// File: rtl/brent_kung_subtractor_pipe.sv
// Three-stage pipelined subtractor, diff = a - b = a + ~b + 1, using a
// Brent-Kung prefix carry network split across stages 2 and 3.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready = pipeline advance enable)
//   a, b                : minuend and subtrahend, WIDTH bits
//   out_valid/out_ready : result handshake
//   diff                : a - b mod 2^WIDTH
//   borrow              : 1 iff a < b unsigned (inverse of carry out)
//   overflow            : signed overflow of a - b
// The whole pipeline advances together when the output slot is empty or being
// consumed; otherwise every stage holds, so up to three operations stay in flight.
module brent_kung_subtractor_pipe
    import bk_arith_pkg::*;
#(
    parameter int unsigned WIDTH = BK_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    logic             en_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] g_s;
    gp_t  [WIDTH-1:0] gp1_s;
    gp_t  [WIDTH-1:0] gp2_s;
    gp_t  [WIDTH-1:0] gp3_s;
    logic [WIDTH-1:0] c_s;
    logic [WIDTH-1:0] diff_s;
    logic             carry_out_s;
    logic             overflow_s;
    logic [WIDTH-1:0] unused_p3_s;

    logic             v1_r;
    gp_t  [WIDTH-1:0] gp1_r;
    logic [WIDTH-1:0] p1_r;
    logic             a_msb1_r;
    logic             b_msb1_r;

    logic             v2_r;
    gp_t  [WIDTH-1:0] gp2_r;
    logic [WIDTH-1:0] p2_r;
    logic             a_msb2_r;
    logic             b_msb2_r;

    logic             out_valid_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             overflow_r;

    assign en_s     = ~out_valid_r | out_ready;
    assign in_ready = en_s;

    // Bit-level terms against the inverted subtrahend.
    assign p_s = ~(a ^ b);
    assign g_s = a & ~b;

    // The constant carry-in (g[-1] = 1) is folded into node 0, so every tree
    // node i ends up holding G[i:-1]; only bit 0 changes: g0 | p0.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pg
        if (gi == 0) begin : g_lsb
            assign gp1_s[gi] = {g_s[gi] | p_s[gi], p_s[gi]};
        end else begin : g_rest
            assign gp1_s[gi] = {g_s[gi], p_s[gi]};
        end
    end

    // Stage 1 registers: folded (g,p) nodes, raw propagate and sign bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r     <= 1'b0;
            gp1_r    <= '0;
            p1_r     <= '0;
            a_msb1_r <= 1'b0;
            b_msb1_r <= 1'b0;
        end else if (en_s) begin
            v1_r     <= in_valid & en_s;
            gp1_r    <= gp1_s;
            p1_r     <= p_s;
            a_msb1_r <= a[WIDTH-1];
            b_msb1_r <= b[WIDTH-1];
        end
    end

    bk_prefix_tree #(
        .WIDTH (WIDTH),
        .MODE  (UPSWEEP)
    ) u_upsweep (
        .gp_in  (gp1_r),
        .gp_out (gp2_s)
    );

    // Stage 2 registers: up-sweep tree nodes plus the values carried alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r     <= 1'b0;
            gp2_r    <= '0;
            p2_r     <= '0;
            a_msb2_r <= 1'b0;
            b_msb2_r <= 1'b0;
        end else if (en_s) begin
            v2_r     <= v1_r;
            gp2_r    <= gp2_s;
            p2_r     <= p1_r;
            a_msb2_r <= a_msb1_r;
            b_msb2_r <= b_msb1_r;
        end
    end

    bk_prefix_tree #(
        .WIDTH (WIDTH),
        .MODE  (DOWNSWEEP)
    ) u_downsweep (
        .gp_in  (gp2_r),
        .gp_out (gp3_s)
    );

    // Carry into bit i is the full prefix of everything below it, carry-in included.
    assign c_s[0] = 1'b1;
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
        assign c_s[gi] = gp3_s[gi-1].g;
    end

    // Group propagates after the down-sweep are not needed for the sum.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_unused_p
        assign unused_p3_s[gi] = gp3_s[gi].p;
    end

    assign diff_s      = p2_r ^ c_s;
    assign carry_out_s = gp3_s[WIDTH-1].g;
    assign overflow_s  = (a_msb2_r ^ b_msb2_r) & (diff_s[WIDTH-1] ^ a_msb2_r);

    // Stage 3 output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            diff_r      <= '0;
            borrow_r    <= 1'b0;
            overflow_r  <= 1'b0;
        end else if (en_s) begin
            out_valid_r <= v2_r;
            diff_r      <= diff_s;
            borrow_r    <= ~carry_out_s;
            overflow_r  <= overflow_s;
        end
    end

    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign borrow    = borrow_r;
    assign overflow  = overflow_r;

endmodule
